// File: rtl/md_unit_pkg.sv
// Shared CPU definitions for the multiply/divide unit: op encodings, default
// latencies and controller state type.
`timescale 1ns/1ps
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } md_state_e;

endpackage

// File: rtl/md_unit.sv
// HI/LO multiply-divide unit: fixed-latency mult/div with latched operands,
// zero-latency mthi/mtlo, and a combinational HI/LO read port.
`timescale 1ns/1ps
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] sa, sb, quot_s, rem_s;
  logic [31:0]        b_nz, quot_u, rem_u;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Divisor forced nonzero so the dividers never see 0; such results are discarded anyway.
  always_comb begin
    b_nz   = (b_q == '0) ? 32'd1 : b_q;
    sa     = $signed(a_q);
    sb     = $signed(b_nz);
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
      quot_s = 32'sh8000_0000;
      rem_s  = '0;
    end else begin
      quot_s = sa / sb;
      rem_s  = sa % sb;
    end
    quot_u = a_q / b_nz;
    rem_u  = a_q % b_nz;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = StRun;
            end
            MD_DIV, MD_DIVU: begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              cnt_d   = CntW'(DIV_CYCLES);
              state_d = StRun;
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          case (op_q)
            MD_MULT:  {hi_d, lo_d} = prod_s;
            MD_MULTU: {hi_d, lo_d} = prod_u;
            MD_DIV: begin
              if (b_q != '0) begin
                lo_d = quot_s;
                hi_d = rem_s;
              end
            end
            MD_DIVU: begin
              if (b_q != '0) begin
                lo_d = quot_u;
                hi_d = rem_u;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy    = (state_q == StRun);
    hi      = hi_q;
    lo      = lo_q;
    rd_data = rd_sel ? hi_q : lo_q;
  end

endmodule
